// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low segment
// patterns (bit0=a .. bit6=g), special BCD codes and the capture FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Reverse lookup of one active-low segment pattern into a BCD code,
// flagging blank (all segments off) and illegal patterns.
module seg7_pattern_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] code,
  output logic       blank,
  output logic       err
);

  // Pattern to code table; anything unlisted is an error
  always_comb begin
    code  = BCD_ERR;
    blank = 1'b0;
    err   = 1'b0;
    case (seg_n)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: begin
        code  = BCD_BLANK;
        blank = 1'b1;
      end
      default: begin
        code = BCD_ERR;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed active-low 7-segment bus, de-glitches each digit and
// publishes the decoded multi-digit BCD word once every digit has been seen.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

  logic [6:0]            seg_s1_r;
  logic [6:0]            seg_s2_r;
  logic [DIGITS-1:0]     an_s1_r;
  logic [DIGITS-1:0]     an_s2_r;

  logic                  strobe_ok_s;
  logic [IDX_W-1:0]      strobe_idx_s;
  logic                  same_s;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic [6:0]            pat_r;
  logic [6:0]            pat_nxt_s;
  logic                  capture_s;

  logic [3:0]            dec_code_s;
  logic                  dec_blank_s;
  logic                  dec_err_s;

  logic [DIGITS-1:0][3:0] stage_code_r;
  logic [DIGITS-1:0][3:0] stage_code_nxt_s;
  logic [DIGITS-1:0]      stage_blank_r;
  logic [DIGITS-1:0]      stage_blank_nxt_s;
  logic [DIGITS-1:0]      stage_err_r;
  logic [DIGITS-1:0]      stage_err_nxt_s;
  logic [DIGITS-1:0]      seen_r;
  logic [DIGITS-1:0]      slot_onehot_s;
  logic                   commit_s;

  // Two-flop synchronizer; resets to the idle (all ones) bus
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s1_r <= {7{1'b1}};
      seg_s2_r <= {7{1'b1}};
      an_s1_r  <= {DIGITS{1'b1}};
      an_s2_r  <= {DIGITS{1'b1}};
    end else begin
      seg_s1_r <= seg_n;
      seg_s2_r <= seg_s1_r;
      an_s1_r  <= an_n;
      an_s2_r  <= an_s1_r;
    end
  end

  // Strobe qualification: exactly one anode low selects a digit
  always_comb begin
    strobe_ok_s  = ($countones(~an_s2_r) == 32'd1);
    strobe_idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      strobe_idx_s = strobe_idx_s | (an_s2_r[i] ? {IDX_W{1'b0}} : IDX_W'(i));
    end
  end

  assign same_s = strobe_ok_s && (strobe_idx_s == idx_r) && (seg_s2_r == pat_r);

  // Stability tracking; capture fires on the cycle the count reaches the limit
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    pat_nxt_s   = pat_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (strobe_ok_s) begin
          state_nxt_s = TRACK;
          cnt_nxt_s   = CNT_ONE;
          idx_nxt_s   = strobe_idx_s;
          pat_nxt_s   = seg_s2_r;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      TRACK, HELD: begin
        if (same_s) begin
          state_nxt_s = state_r;
          cnt_nxt_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
        end else if (strobe_ok_s) begin
          state_nxt_s = TRACK;
          cnt_nxt_s   = CNT_ONE;
          idx_nxt_s   = strobe_idx_s;
          pat_nxt_s   = seg_s2_r;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
    // HELD is left only through a change, so a capture happens once per run
    if ((state_nxt_s == TRACK) && (cnt_nxt_s == CNT_MAX)) begin
      state_nxt_s = HELD;
      capture_s   = 1'b1;
    end else begin
      capture_s   = 1'b0;
    end
  end

  seg7_pattern_to_bcd u_decode (
    .seg_n (pat_nxt_s),
    .code  (dec_code_s),
    .blank (dec_blank_s),
    .err   (dec_err_s)
  );

  // Staging view including the slot written this cycle, so commit sees it
  always_comb begin
    stage_code_nxt_s  = stage_code_r;
    stage_blank_nxt_s = stage_blank_r;
    stage_err_nxt_s   = stage_err_r;
    if (capture_s) begin
      stage_code_nxt_s[idx_nxt_s]  = dec_code_s;
      stage_blank_nxt_s[idx_nxt_s] = dec_blank_s;
      stage_err_nxt_s[idx_nxt_s]   = dec_err_s;
    end else begin
      stage_code_nxt_s  = stage_code_r;
      stage_blank_nxt_s = stage_blank_r;
      stage_err_nxt_s   = stage_err_r;
    end
  end

  assign slot_onehot_s = DIGITS'(1'b1) << idx_nxt_s;
  assign commit_s      = capture_s && (&(seen_r | slot_onehot_s));

  // FSM state and latched digit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= {IDX_W{1'b0}};
      pat_r   <= {7{1'b1}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      pat_r   <= pat_nxt_s;
    end
  end

  // Staging slots and per-frame seen mask
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_code_r  <= {(4*DIGITS){1'b0}};
      stage_blank_r <= {DIGITS{1'b0}};
      stage_err_r   <= {DIGITS{1'b0}};
      seen_r        <= {DIGITS{1'b0}};
    end else begin
      stage_code_r  <= stage_code_nxt_s;
      stage_blank_r <= stage_blank_nxt_s;
      stage_err_r   <= stage_err_nxt_s;
      if (commit_s) begin
        seen_r <= {DIGITS{1'b0}};
      end else if (capture_s) begin
        seen_r <= seen_r | slot_onehot_s;
      end else begin
        seen_r <= seen_r;
      end
    end
  end

  // Published frame; changes only on commit
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_out     <= {(4*DIGITS){1'b0}};
      blank       <= {DIGITS{1'b0}};
      digit_err   <= {DIGITS{1'b0}};
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= commit_s;
      if (commit_s) begin
        bcd_out   <= stage_code_nxt_s;
        blank     <= stage_blank_nxt_s;
        digit_err <= stage_err_nxt_s;
      end else begin
        bcd_out   <= bcd_out;
        blank     <= blank;
        digit_err <= digit_err;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench: a pin-level reference model predicts each frame (time and
// contents) into a queue; a negedge monitor pops and compares on frame_valid.
module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int STAB   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] bcd_out;
  logic [3:0]  blank;
  logic [3:0]  digit_err;
  logic        frame_valid;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STAB)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .bcd_out     (bcd_out),
    .blank       (blank),
    .digit_err   (digit_err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] bcd;
    logic [3:0]  blk;
    logic [3:0]  err;
  } frame_t;

  frame_t exp_q[$];
  frame_t mon_f;
  frame_t push_f;

  int total  = 0;
  int bad    = 0;
  int pulses = 0;
  int cyc    = 0;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0011000};

  // reference model state
  int              run = 0;
  logic [3:0]      prev_an = 4'hF;
  logic [6:0]      prev_seg = 7'h7F;
  logic            pend1_v = 1'b0, pend2_v = 1'b0;
  int              pend1_d = 0, pend2_d = 0;
  logic [6:0]      pend1_p, pend2_p;
  logic [3:0][3:0] m_code = 16'h0;
  logic [3:0]      m_blk = 4'h0, m_err = 4'h0, m_seen = 4'h0;
  logic [15:0]     cur_bcd = 16'h0;
  logic [3:0]      cur_blk = 4'h0, cur_err = 4'h0;

  function automatic int low_idx(input logic [3:0] a);
    int r = 0;
    for (int k = 0; k < DIGITS; k++) if (!a[k]) r = k;
    return r;
  endfunction

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] c,
                                     output logic b, output logic e);
    c = 4'hE; b = 1'b0; e = 1'b1;
    if (p == 7'h7F) begin c = 4'hF; b = 1'b1; e = 1'b0; end
    for (int k = 0; k < 10; k++) if (seg_tab[k] == p) begin c = 4'(k); e = 1'b0; end
  endfunction

  // A capture lands two edges after the pins have held steady STAB edges
  always @(posedge clk) begin
    logic [3:0] c;
    logic       b, e, valid;
    cyc = cyc + 1;
    if (reset) begin
      run = 0; pend1_v = 1'b0; pend2_v = 1'b0;
      m_code = 16'h0; m_blk = 4'h0; m_err = 4'h0; m_seen = 4'h0;
      cur_bcd = 16'h0; cur_blk = 4'h0; cur_err = 4'h0;
    end else begin
      if (pend2_v) begin
        ref_decode(pend2_p, c, b, e);
        m_code[pend2_d] = c; m_blk[pend2_d] = b; m_err[pend2_d] = e;
        m_seen[pend2_d] = 1'b1;
        if (m_seen == 4'hF) begin
          cur_bcd = m_code; cur_blk = m_blk; cur_err = m_err; m_seen = 4'h0;
          push_f.cyc = cyc; push_f.bcd = cur_bcd; push_f.blk = cur_blk; push_f.err = cur_err;
          exp_q.push_back(push_f);
        end
      end
      pend2_v = pend1_v; pend2_d = pend1_d; pend2_p = pend1_p;
      valid = ($countones(~an_n) == 1);
      if (valid && run > 0 && an_n == prev_an && seg_n == prev_seg) run = run + 1;
      else if (valid) run = 1;
      else run = 0;
      prev_an = an_n; prev_seg = seg_n;
      pend1_v = (run == STAB); pend1_d = low_idx(an_n); pend1_p = seg_n;
    end
  end

  // Monitor: every frame_valid must match the head of the expected queue
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      pulses = pulses + 1;
      total  = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL frame_unexpected: cycle %0d got bcd=%h, required no frame", cyc, bcd_out);
      end else begin
        mon_f = exp_q.pop_front();
        if (mon_f.cyc != cyc || bcd_out !== mon_f.bcd || blank !== mon_f.blk || digit_err !== mon_f.err) begin
          bad = bad + 1;
          $display("FAIL frame_check: got cyc=%0d bcd=%h blank=%b err=%b, required cyc=%0d bcd=%h blank=%b err=%b",
                   cyc, bcd_out, blank, digit_err, mon_f.cyc, mon_f.bcd, mon_f.blk, mon_f.err);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      total = total + 1;
      bad   = bad + 1;
      mon_f = exp_q.pop_front();
      $display("FAIL frame_missing: no pulse at cycle %0d, required bcd=%h", mon_f.cyc, mon_f.bcd);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    an_n = a; seg_n = s; step(n);
  endtask

  task automatic check_out(input string nm, input logic [15:0] eb, input logic [3:0] ebl, input logic [3:0] eer);
    total = total + 1;
    if (bcd_out !== eb || blank !== ebl || digit_err !== eer) begin
      bad = bad + 1;
      $display("FAIL %s: got bcd=%h blank=%b err=%b, required bcd=%h blank=%b err=%b",
               nm, bcd_out, blank, digit_err, eb, ebl, eer);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int expv);
    total = total + 1;
    if (got != expv) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d, required %0d", nm, got, expv);
    end
  endtask

  task automatic random_burst(input int n);
    logic [3:0] a;
    logic [6:0] s;
    int         r;
    for (int k = 0; k < n; k++) begin
      r = int'($urandom_range(0, 99));
      a = 4'hF;
      a[$urandom_range(0, 3)] = 1'b0;
      if (r < 4) a = 4'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 80) s = seg_tab[$urandom_range(0, 9)];
      else if (r < 90) s = 7'h7F;
      else s = 7'($urandom);
      if ($urandom_range(0, 99) < 2) begin
        reset = 1'b1; step(1); reset = 1'b0;
      end
      show(a, s, int'($urandom_range(1, 8)));
    end
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    an_n  = 4'($urandom);
    seg_n = 7'($urandom);
    step(3);
    check_out("t1_reset", 16'h0, 4'h0, 4'h0);
    reset = 1'b0;
    show(4'hF, 7'h7F, 10);
    check_out("t1_idle", 16'h0, 4'h0, 4'h0);
    check_int("t1_pulses", pulses, 0);

    // Test 2: full scan 1,2,3,4
    p0 = pulses;
    show(4'b1110, seg_tab[1], 6);
    show(4'b1101, seg_tab[2], 6);
    show(4'b1011, seg_tab[3], 6);
    show(4'b0111, seg_tab[4], 6);
    check_int("t2_latency", int'(frame_valid), 1);
    show(4'hF, 7'h7F, 6);
    check_int("t2_pulses", pulses - p0, 1);
    check_out("t2_frame", 16'h4321, 4'h0, 4'h0);

    // Test 3: digit 1 too short, then re-strobed
    p0 = pulses;
    show(4'b1110, seg_tab[1], 6);
    show(4'b1101, seg_tab[2], 3);
    show(4'b1011, seg_tab[3], 6);
    show(4'b0111, seg_tab[4], 6);
    show(4'hF, 7'h7F, 8);
    check_int("t3_short_no_frame", pulses - p0, 0);
    show(4'b1101, seg_tab[2], 6);
    check_int("t3_restrobe_latency", int'(frame_valid), 1);
    show(4'hF, 7'h7F, 6);
    check_int("t3_pulses", pulses - p0, 1);
    check_out("t3_frame", 16'h4321, 4'h0, 4'h0);

    // Test 4: error and blank digits
    show(4'b1110, seg_tab[8], 6);
    show(4'b1101, seg_tab[9], 6);
    show(4'b1011, 7'b0000001, 6);
    show(4'b0111, 7'b1111111, 6);
    show(4'hF, 7'h7F, 6);
    check_out("t4_err_blank", 16'hFE98, 4'b1000, 4'b0100);

    // Test 5: invalid strobes never capture
    p0 = pulses;
    show(4'b1100, seg_tab[3], 20);
    show(4'b1111, seg_tab[3], 20);
    check_int("t5_no_frame", pulses - p0, 0);
    check_out("t5_hold", 16'hFE98, 4'b1000, 4'b0100);

    // Test 6: reset mid-frame discards partial frame
    p0 = pulses;
    show(4'b1110, seg_tab[5], 6);
    show(4'b1101, seg_tab[6], 6);
    reset = 1'b1; an_n = 4'hF; seg_n = 7'h7F; step(1); reset = 1'b0;
    show(4'b1011, seg_tab[7], 6);
    show(4'b0111, seg_tab[0], 6);
    show(4'hF, 7'h7F, 8);
    check_int("t6_no_frame", pulses - p0, 0);
    check_out("t6_after_reset", 16'h0, 4'h0, 4'h0);
    show(4'b1110, seg_tab[5], 6);
    show(4'b1101, seg_tab[6], 6);
    show(4'b1011, seg_tab[7], 6);
    show(4'b0111, seg_tab[0], 6);
    show(4'hF, 7'h7F, 6);
    check_int("t6_pulses", pulses - p0, 1);
    check_out("t6_frame", 16'h0765, 4'h0, 4'h0);

    // Randomized scans against the model
    for (int r = 0; r < 30; r++) begin
      random_burst(12);
      show(4'hF, 7'h7F, 4);
      check_out("rand_hold", cur_bcd, cur_blk, cur_err);
    end

    show(4'hF, 7'h7F, 4);
    check_int("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
